// File: rtl/byang_host_link_if.sv
// Interface: byang_host_link_if
// Groups every non-clock/reset signal of the byte-wide modular-inverse host link.
//   Host side : in_valid/in_ready/in_operand (operand stream in),
//               out_valid/out_ready/out_result/out_cycles/out_err (result stream out), busy.
//   Pin side  : pin_ui/pin_wr/pin_rd (to device), pin_uo/pin_dev_ready/pin_dev_valid (from device).
// Modports:
//   master - the host link itself (drives in_ready, out_*, busy and the pin outputs).
//   slave  - the environment around it (operand producer, result consumer, device pins).
interface byang_host_link_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_operand;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_result;
  logic [9:0]   out_cycles;
  logic         out_err;
  logic         busy;
  logic [7:0]   pin_ui;
  logic [7:0]   pin_uo;
  logic         pin_wr;
  logic         pin_rd;
  logic         pin_dev_ready;
  logic         pin_dev_valid;

  modport master (
    input  in_valid, in_operand, out_ready, pin_uo, pin_dev_ready, pin_dev_valid,
    output in_ready, out_valid, out_result, out_cycles, out_err, busy, pin_ui, pin_wr, pin_rd
  );

  modport slave (
    output in_valid, in_operand, out_ready, pin_uo, pin_dev_ready, pin_dev_valid,
    input  in_ready, out_valid, out_result, out_cycles, out_err, busy, pin_ui, pin_wr, pin_rd
  );
endinterface

// File: rtl/byang_host_link.sv
// Module: byang_host_link
// Host-side master for the byte-wide modular-inverse pin protocol. Takes a 256-bit operand over
// valid/ready, writes it to the device MSB-first with pin_wr strobes, polls the device valid pin,
// then reads the 256-bit inverse back MSB-first with pin_rd strobes and offers it on out_*.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high; aborts any transfer and drops both strobes at once
//   bus  - byang_host_link_if.master:
//          in_valid/in_ready/in_operand          operand handshake (in_ready high only in idle)
//          out_valid/out_ready/out_result/
//          out_cycles/out_err                    result handshake (held until out_ready)
//          busy                                  high whenever not idle
//          pin_ui/pin_wr/pin_rd                  byte out, write strobe, read strobe
//          pin_uo/pin_dev_ready/pin_dev_valid    byte in, device ready/valid (synchronized here)
//
// Parameters:
//   STROBE_CYCLES  - cycles of each strobe high phase and each strobe low phase (>= 1)
//   SETTLE_CYCLES  - cycles between driving pin_ui / dropping pin_rd and wr rise / uo sample (>= 1)
//   TIMEOUT_CYCLES - cycles waited for the device (ready/valid) before flagging out_err
//
// Build option: define BYANG_CYCLES_RDBK_EN to read two extra bytes after the result and
// report the device cycle count on out_cycles; otherwise out_cycles is tied to zero.
module byang_host_link #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  byang_host_link_if.master bus
);

  localparam int unsigned TmrMax = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES
                                                                    : SETTLE_CYCLES;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TmrW-1:0] StrobeLast = TmrW'(STROBE_CYCLES - 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast    = TmoW'(TIMEOUT_CYCLES - 1);

  // Bytes 0..31 carry the result; with cycle readback, bytes 32/33 carry the cycle count.
  localparam logic [5:0] ResultBytes = 6'd32;
`ifdef BYANG_CYCLES_RDBK_EN
  localparam logic [5:0] LastByte    = 6'd33;
`else
  localparam logic [5:0] LastByte    = 6'd31;
`endif

  typedef enum logic [3:0] {
    StIdle,
    StWaitDev,
    StWSetup,
    StWHi,
    StWLo,
    StPoll,
    StRSettle,
    StRHi,
    StRLo,
    StOut
  } state_e;

  state_e          state_q;
  logic [255:0]    sreg_q;
  logic [5:0]      byte_idx_q;
  logic [TmrW-1:0] tmr_q;
  logic [TmoW-1:0] tmo_q;
  logic [7:0]      pin_ui_q;
  logic            pin_wr_q;
  logic            pin_rd_q;
  logic            out_valid_q;
  logic            out_err_q;
  logic [255:0]    out_result_q;

  // Two-flop synchronizers for the device status pins.
  logic rdy_m, rdy_s;
  logic val_m, val_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
      val_m <= 1'b0;
      val_s <= 1'b0;
    end else begin
      rdy_m <= bus.pin_dev_ready;
      rdy_s <= rdy_m;
      val_m <= bus.pin_dev_valid;
      val_s <= val_m;
    end
  end

`ifdef BYANG_CYCLES_RDBK_EN
  logic [1:0] cyc_hi_q;
  logic [9:0] out_cycles_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      byte_idx_q   <= '0;
      tmr_q        <= '0;
      tmo_q        <= '0;
      pin_ui_q     <= '0;
      pin_wr_q     <= 1'b0;
      pin_rd_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
`ifdef BYANG_CYCLES_RDBK_EN
      cyc_hi_q     <= '0;
      out_cycles_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            sreg_q       <= bus.in_operand;
            byte_idx_q   <= '0;
            tmr_q        <= '0;
            tmo_q        <= '0;
            out_err_q    <= 1'b0;
            out_result_q <= '0;
`ifdef BYANG_CYCLES_RDBK_EN
            out_cycles_q <= '0;
`endif
            state_q      <= StWaitDev;
          end
        end

        // A device still in its read phase (val_s) restarts loading on the first wr.
        StWaitDev: begin
          if (rdy_s || val_s) begin
            pin_ui_q <= sreg_q[255:248];
            tmr_q    <= '0;
            state_q  <= StWSetup;
          end else if (tmo_q == TmoLast) begin
            out_err_q    <= 1'b1;
            out_result_q <= '0;
            out_valid_q  <= 1'b1;
            state_q      <= StOut;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        StWSetup: begin
          if (tmr_q == SettleLast) begin
            tmr_q    <= '0;
            pin_wr_q <= 1'b1;
            state_q  <= StWHi;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StWHi: begin
          if (tmr_q == StrobeLast) begin
            tmr_q    <= '0;
            pin_wr_q <= 1'b0;
            state_q  <= StWLo;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        // pin_ui only changes here, after the low phase, so it is stable across the whole strobe.
        StWLo: begin
          if (tmr_q == StrobeLast) begin
            tmr_q  <= '0;
            sreg_q <= {sreg_q[247:0], 8'h00};
            if (byte_idx_q == ResultBytes - 6'd1) begin
              byte_idx_q <= '0;
              tmo_q      <= '0;
              state_q    <= StPoll;
            end else begin
              byte_idx_q <= byte_idx_q + 6'd1;
              pin_ui_q   <= sreg_q[247:240];
              state_q    <= StWSetup;
            end
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StPoll: begin
          if (val_s) begin
            tmr_q   <= '0;
            state_q <= StRSettle;
          end else if (tmo_q == TmoLast) begin
            out_err_q    <= 1'b1;
            out_result_q <= '0;
            out_valid_q  <= 1'b1;
            state_q      <= StOut;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        // Byte 0 is presented as soon as valid rises; later bytes follow each rd strobe.
        StRSettle: begin
          if (tmr_q == SettleLast) begin
            tmr_q <= '0;
            if (byte_idx_q < ResultBytes) begin
              out_result_q <= {out_result_q[247:0], bus.pin_uo};
            end
`ifdef BYANG_CYCLES_RDBK_EN
            else begin
              cyc_hi_q <= bus.pin_uo[1:0];
            end
`endif
            if (byte_idx_q == LastByte) begin
`ifdef BYANG_CYCLES_RDBK_EN
              out_cycles_q <= {cyc_hi_q, bus.pin_uo};
`endif
              out_valid_q <= 1'b1;
              state_q     <= StOut;
            end else begin
              byte_idx_q <= byte_idx_q + 6'd1;
              pin_rd_q   <= 1'b1;
              state_q    <= StRHi;
            end
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StRHi: begin
          if (tmr_q == StrobeLast) begin
            tmr_q    <= '0;
            pin_rd_q <= 1'b0;
            state_q  <= StRLo;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StRLo: begin
          if (tmr_q == StrobeLast) begin
            tmr_q   <= '0;
            state_q <= StRSettle;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end

        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: begin
          pin_wr_q <= 1'b0;
          pin_rd_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  // in_ready is gated by rst so it reads low for the whole reset pulse.
  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_result = out_result_q;
  assign bus.pin_ui     = pin_ui_q;
  assign bus.pin_wr     = pin_wr_q;
  assign bus.pin_rd     = pin_rd_q;
`ifdef BYANG_CYCLES_RDBK_EN
  assign bus.out_cycles = out_cycles_q;
`else
  assign bus.out_cycles = 10'd0;
`endif

endmodule

// File: tb/tb_byang_host_link.sv
// Bench for byang_host_link: a behavioural device model on the pins plus per-scenario tasks.
module tb_byang_host_link;

  localparam int unsigned StrobeCycles  = 2;
  localparam int unsigned SettleCycles  = 2;
  localparam int unsigned TimeoutCycles = 64;
`ifdef BYANG_CYCLES_RDBK_EN
  localparam int ExpRdStrobes = 33;
  localparam bit CycEn        = 1'b1;
`else
  localparam int ExpRdStrobes = 31;
  localparam bit CycEn        = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byang_host_link_if bus ();

  byang_host_link #(
    .STROBE_CYCLES (StrobeCycles),
    .SETTLE_CYCLES (SettleCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference functions ----------------
  // Inverse modulo 2^256 by Newton iteration; even operands have none and map to 0.
  function automatic logic [255:0] ref_inverse(input logic [255:0] x);
    logic [255:0] y;
    if (!x[0]) return '0;
    y = x;
    for (int i = 0; i < 8; i++) y = y * (256'd2 - x * y);
    return y;
  endfunction

  function automatic logic [9:0] ref_cycles(input logic [255:0] x);
    if (x == 256'd1) return 10'd742;
    return x[9:0] ^ 10'h2b5;
  endfunction

  function automatic logic [255:0] rand_op();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    v[0] = 1'b1;
    return v;
  endfunction

  // ---------------- device model ----------------
  localparam int MLoad = 0, MComp = 1, MRead = 2, MStuck = 3;
  int           m_state = MLoad;
  int           m_nbytes = 0;
  int           m_delay = 0;
  int           m_ridx = 0;
  logic [255:0] m_opnd = '0;
  logic [255:0] m_res;
  logic [9:0]   m_cyc;
  logic [7:0]   m_bytes [34];
  logic         m_prev_wr = 1'b0;
  logic         m_prev_rd = 1'b0;
  bit           m_hang = 1'b0;
  bit           m_rst_req = 1'b0;
  logic [7:0]   wr_log [$];
  int           rd_rises = 0;

  always @(posedge clk) begin
    if (m_rst_req) begin
      m_state  = MLoad;
      m_nbytes = 0;
      m_ridx   = 0;
      m_delay  = 0;
    end else begin
      if (bus.pin_wr && !m_prev_wr) begin
        wr_log.push_back(bus.pin_ui);
        if (m_state == MRead) begin
          m_state  = MLoad;
          m_nbytes = 0;
        end
        if (m_state == MLoad) begin
          m_opnd = {m_opnd[247:0], bus.pin_ui};
          m_nbytes++;
          if (m_nbytes == 32) begin
            m_state = m_hang ? MStuck : MComp;
            m_delay = 12;
          end
        end
      end
      if (bus.pin_rd && !m_prev_rd) begin
        rd_rises++;
        if (m_state == MRead && m_ridx < 33) m_ridx++;
      end
      if (m_state == MComp) begin
        if (m_delay == 0) begin
          m_res = ref_inverse(m_opnd);
          m_cyc = ref_cycles(m_opnd);
          for (int i = 0; i < 32; i++) m_bytes[i] = m_res[255-8*i -: 8];
          m_bytes[32] = {6'b101101, m_cyc[9:8]};
          m_bytes[33] = m_cyc[7:0];
          m_ridx  = 0;
          m_state = MRead;
        end else begin
          m_delay--;
        end
      end
    end
    m_prev_wr = bus.pin_wr;
    m_prev_rd = bus.pin_rd;
    bus.pin_dev_ready <= (m_state == MLoad);
    bus.pin_dev_valid <= (m_state == MRead);
    bus.pin_uo        <= (m_state == MRead) ? m_bytes[m_ridx] : 8'h00;
  end

  // ---------------- pin monitors ----------------
  int         overlap_cnt = 0;
  int         ui_change_cnt = 0;
  logic       mon_prev_wr = 1'b0;
  logic [7:0] mon_prev_ui = 8'h00;
  always @(negedge clk) begin
    if (bus.pin_wr === 1'b1 && bus.pin_rd === 1'b1) overlap_cnt++;
    if (bus.pin_wr === 1'b1 && mon_prev_wr === 1'b1 && bus.pin_ui !== mon_prev_ui) ui_change_cnt++;
    mon_prev_wr = bus.pin_wr;
    mon_prev_ui = bus.pin_ui;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  int wr_base = 0;
  int rd_base = 0;

  task automatic send_op(input logic [255:0] op, output bit done);
    done    = 1'b0;
    wr_base = wr_log.size();
    rd_base = rd_rises;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_operand = op;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic model_reset();
    @(negedge clk);
    m_rst_req = 1'b1;
    @(negedge clk);
    m_rst_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.pin_wr, bus.pin_rd} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.in_ready, bus.out_valid, bus.out_err, bus.busy, bus.pin_wr, bus.pin_rd});
    end
    vectors++;
    if (bus.out_result !== '0 || bus.out_cycles !== 10'd0 || bus.pin_ui !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: result %h cycles %0d ui %h want all 0",
               bus.out_result, bus.out_cycles, bus.pin_ui);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_operand_one();
    bit done;
    int bad;
    logic [7:0] expb;
    send_op(256'd1, done);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL one_done: out_valid never rose");
    end
    vectors++;
    if (wr_log.size() - wr_base != 32) begin
      miscompares++;
      $display("FAIL one_wr_count: got %0d want 32", wr_log.size() - wr_base);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      expb = (i == 31) ? 8'h01 : 8'h00;
      if (wr_base + i >= wr_log.size() || wr_log[wr_base + i] !== expb) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL one_wr_bytes: %0d bytes wrong want 0", bad);
    end
    vectors++;
    if (bus.out_result !== 256'd1 || bus.out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL one_result: got %h err %b want 1 err 0", bus.out_result, bus.out_err);
    end
    vectors++;
    if (bus.out_cycles !== (CycEn ? 10'd742 : 10'd0)) begin
      miscompares++;
      $display("FAIL one_cycles: got %0d want %0d", bus.out_cycles, CycEn ? 742 : 0);
    end
    vectors++;
    if (rd_rises - rd_base != ExpRdStrobes) begin
      miscompares++;
      $display("FAIL one_rd_count: got %0d want %0d", rd_rises - rd_base, ExpRdStrobes);
    end
    accept_result();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL one_accept: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_pattern();
    bit done;
    int bad;
    logic [255:0] op;
    op = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
    send_op(op, done);
    bad = (wr_log.size() - wr_base == 32) ? 0 : 1;
    for (int i = 0; i < 32; i++) begin
      if (wr_base + i >= wr_log.size() || wr_log[wr_base + i] !== op[255-8*i -: 8]) bad++;
    end
    vectors++;
    if (!done || bad != 0) begin
      miscompares++;
      $display("FAIL pattern_wr: done %b bad bytes %0d want 1 0", done, bad);
    end
    vectors++;
    if (bus.out_result !== ref_inverse(op) || bus.out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pattern_result: got %h want %h", bus.out_result, ref_inverse(op));
    end
    vectors++;
    if (rd_rises - rd_base != ExpRdStrobes) begin
      miscompares++;
      $display("FAIL pattern_rd_count: got %0d want %0d", rd_rises - rd_base, ExpRdStrobes);
    end
    accept_result();
  endtask

  task automatic test_timeout();
    bit done;
    m_hang = 1'b1;
    send_op(rand_op(), done);
    vectors++;
    if (!done || bus.out_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err: done %b err %b want 1 1", done, bus.out_err);
    end
    vectors++;
    if (bus.out_result !== '0 || bus.out_cycles !== 10'd0) begin
      miscompares++;
      $display("FAIL timeout_result: got %h cycles %0d want 0", bus.out_result, bus.out_cycles);
    end
    vectors++;
    if (rd_rises - rd_base != 0) begin
      miscompares++;
      $display("FAIL timeout_rd: got %0d strobes want 0", rd_rises - rd_base);
    end
    accept_result();
    m_hang = 1'b0;
    model_reset();
  endtask

  task automatic test_hold();
    bit done;
    logic [255:0] op;
    logic [255:0] expr;
    op   = rand_op();
    expr = ref_inverse(op);
    send_op(op, done);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL hold_done: out_valid never rose");
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== expr || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid %b in_ready %b result %h want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_result, expr);
      end
      @(negedge clk);
    end
    accept_result();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  // Device is left in its read phase by the previous op, so each op here restarts it with wr.
  task automatic test_back_to_back();
    bit done;
    logic [255:0] op;
    for (int k = 0; k < 4; k++) begin
      op = rand_op();
      if (k == 2) op[0] = 1'b0;
      send_op(op, done);
      vectors++;
      if (!done || wr_log.size() - wr_base != 32) begin
        miscompares++;
        $display("FAIL b2b%0d_wr: done %b wr %0d want 1 32", k, done, wr_log.size() - wr_base);
      end
      vectors++;
      if (bus.out_result !== ref_inverse(op) || bus.out_err !== 1'b0 ||
          bus.out_cycles !== (CycEn ? ref_cycles(op) : 10'd0)) begin
        miscompares++;
        $display("FAIL b2b%0d_result: got %h err %b cyc %0d want %h",
                 k, bus.out_result, bus.out_err, bus.out_cycles, ref_inverse(op));
      end
      accept_result();
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    bit found;
    int n;
    logic prev;
    logic [255:0] op;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_operand = rand_op();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n     = 0;
    prev  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.pin_wr === 1'b1 && prev !== 1'b1) n++;
      prev = bus.pin_wr;
      if (n == 18 && bus.pin_wr === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midrst_reach: byte 17 strobe seen %b want 1", found);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.pin_wr !== 1'b0 || bus.pin_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_strobe: wr %b rd %b want 0 0", bus.pin_wr, bus.pin_rd);
    end
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.busy} !== 4'b0 || bus.pin_ui !== 8'h00 ||
        bus.out_result !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: ctrl %b ui %h result %h want 0",
               {bus.in_ready, bus.out_valid, bus.out_err, bus.busy}, bus.pin_ui, bus.out_result);
    end
    model_reset();
    rst = 1'b0;
    op  = rand_op();
    send_op(op, done);
    vectors++;
    if (!done || bus.out_result !== ref_inverse(op) || wr_log.size() - wr_base != 32) begin
      miscompares++;
      $display("FAIL midrst_fresh: done %b wr %0d result %h want 1 32 %h",
               done, wr_log.size() - wr_base, bus.out_result, ref_inverse(op));
    end
    accept_result();
  endtask

  task automatic test_strobe_discipline();
    vectors++;
    if (overlap_cnt != 0) begin
      miscompares++;
      $display("FAIL strobe_overlap: %0d cycles with wr and rd high want 0", overlap_cnt);
    end
    vectors++;
    if (ui_change_cnt != 0) begin
      miscompares++;
      $display("FAIL ui_stable: %0d changes during wr high want 0", ui_change_cnt);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_operand = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_operand_one();
    test_pattern();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_strobe_discipline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
